// File: rtl/cgra_stream_sequencer_pkg.sv
// rtl/cgra_stream_sequencer_pkg.sv - shared state/mode encodings for the CGRA stream sequencer
package cgra_stream_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    RUN,
    DONE
  } state_t;

  localparam logic [1:0] MODE_INC  = 2'b00;
  localparam logic [1:0] MODE_HOLD = 2'b01;
  localparam logic [1:0] MODE_DEC  = 2'b10;

  // Two cycles covers the memory read latency plus the conf_bus register stage.
  localparam int FLUSH_CYCLES = 2;

endpackage

// File: rtl/cgra_stream_sequencer_if.sv
// rtl/cgra_stream_sequencer_if.sv - config memory, config bus and CGRA stream lanes
interface cgra_stream_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 20,
  parameter int NUM_IN     = 3,
  parameter int NUM_OUT    = 3
);
  logic                          mem_re;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_dout;
  logic [DATA_WIDTH-1:0]         conf_bus;
  logic                          conf_valid;
  logic [NUM_IN*DATA_WIDTH-1:0]  in_stream;
  logic [NUM_OUT*DATA_WIDTH-1:0] out_stream;

  modport master (
    output mem_re, mem_addr, conf_bus, conf_valid, in_stream,
    input  mem_dout, out_stream
  );

  modport slave (
    input  mem_re, mem_addr, conf_bus, conf_valid, in_stream,
    output mem_dout, out_stream
  );
endinterface

// File: rtl/cgra_stream_sequencer_lane.sv
// rtl/cgra_stream_sequencer_lane.sv - one input-stream pattern register (seed+index, then step by mode)
module cgra_stream_sequencer_lane
  import cgra_stream_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANE_INDEX = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic [DATA_WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= seed + DATA_WIDTH'(LANE_INDEX);
    end else if (step) begin
      case (mode)
        MODE_INC:  value <= value + DATA_WIDTH'(1);
        MODE_DEC:  value <= value - DATA_WIDTH'(1);
        MODE_HOLD: value <= value;
        default:   value <= value;
      endcase
    end
  end

endmodule

// File: rtl/cgra_stream_sequencer.sv
// rtl/cgra_stream_sequencer.sv - loads CGRA config words, drives patterned input streams, checksums outputs
module cgra_stream_sequencer
  import cgra_stream_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 20,
  parameter int CONF_WORDS = 1023,
  parameter int NUM_IN     = 3,
  parameter int NUM_OUT    = 3,
  parameter int CSUM_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [31:0]           run_len,
  cgra_stream_sequencer_if.master bus,
  output logic [CSUM_WIDTH-1:0] checksum,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(CONF_WORDS - 1);
  localparam logic [1:0]            LAST_FLUSH = 2'(FLUSH_CYCLES - 1);

  state_t                       state, state_n;
  logic [ADDR_WIDTH-1:0]        load_addr;
  logic [1:0]                   flush_cnt;
  logic [31:0]                  run_cnt;
  logic [1:0]                   mode_q;
  logic [DATA_WIDTH-1:0]        seed_q;
  logic [31:0]                  run_len_q;
  logic                         rd_valid;
  logic                         conf_valid_q;
  logic [DATA_WIDTH-1:0]        conf_bus_q;
  logic [CSUM_WIDTH-1:0]        lane_sum;
  logic [NUM_IN*DATA_WIDTH-1:0] lane_flat;
  logic                         accept;

  assign accept = (state == IDLE) && start && !abort;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = LOAD;
      LOAD:    if (load_addr == LAST_ADDR) state_n = FLUSH;
      FLUSH:   if (flush_cnt == LAST_FLUSH) state_n = RUN;
      RUN:     if (run_len_q != '0 && run_cnt == run_len_q - 32'd1) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      lane_sum = lane_sum + CSUM_WIDTH'(bus.out_stream[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      load_addr    <= '0;
      flush_cnt    <= '0;
      run_cnt      <= '0;
      mode_q       <= '0;
      seed_q       <= '0;
      run_len_q    <= '0;
      rd_valid     <= 1'b0;
      conf_valid_q <= 1'b0;
      conf_bus_q   <= '0;
      checksum     <= '0;
    end else begin
      state     <= state_n;
      load_addr <= (state == LOAD && state_n == LOAD) ? load_addr + ADDR_WIDTH'(1) : '0;
      flush_cnt <= (state == FLUSH && state_n == FLUSH) ? flush_cnt + 2'd1 : '0;
      run_cnt   <= (state == RUN && state_n == RUN) ? run_cnt + 32'd1 : '0;

      // An abort squashes any words still in flight from the memory.
      rd_valid     <= bus.mem_re && !abort;
      conf_valid_q <= rd_valid && !abort;
      conf_bus_q   <= (rd_valid && !abort) ? bus.mem_dout : '0;

      if (accept) begin
        mode_q    <= mode;
        seed_q    <= seed;
        run_len_q <= run_len;
        checksum  <= '0;
      end else if (state == RUN && !abort) begin
        checksum <= checksum + lane_sum;
      end
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    cgra_stream_sequencer_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANE_INDEX (i)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (state == FLUSH && state_n == RUN),
      .step  (state == RUN),
      .mode  (mode_q),
      .seed  (seed_q),
      .value (lane_flat[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign bus.mem_re     = (state == LOAD);
  assign bus.mem_addr   = (state == LOAD) ? load_addr : '0;
  assign bus.conf_valid = conf_valid_q;
  assign bus.conf_bus   = conf_bus_q;
  assign bus.in_stream  = (state == RUN) ? lane_flat : '0;
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);

endmodule

// File: tb/tb_cgra_stream_sequencer.sv
// tb/tb_cgra_stream_sequencer.sv - randomized self-checking bench with a timeline reference model
module tb_cgra_stream_sequencer;

  localparam int DW  = 8;
  localparam int AW  = 20;
  localparam int CW  = 4;
  localparam int NI  = 3;
  localparam int NO  = 3;
  localparam int CSW = 32;
  localparam int OW  = NO * DW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [1:0]     mode = '0;
  logic [DW-1:0]  seed = '0;
  logic [31:0]    run_len = '0;
  logic [CSW-1:0] checksum;
  logic           busy;
  logic           done;

  logic [DW-1:0]  mem [CW];
  int             cyc = 0;
  int             n_tests = 0;
  int             n_fail = 0;
  bit             rand_out = 1'b0;

  bit             m_act = 1'b0;
  int             m_s = 0;
  logic [1:0]     m_mode = '0;
  logic [DW-1:0]  m_seed = '0;
  logic [31:0]    m_rl = '0;
  logic [CSW-1:0] m_csum = '0;

  cgra_stream_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_IN(NI), .NUM_OUT(NO)) bus ();

  cgra_stream_sequencer #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .CONF_WORDS (CW),
    .NUM_IN (NI), .NUM_OUT (NO), .CSUM_WIDTH (CSW)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .abort (abort),
    .mode (mode), .seed (seed), .run_len (run_len),
    .bus (bus.master),
    .checksum (checksum), .busy (busy), .done (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.mem_re === 1'b1) bus.mem_dout <= mem[bus.mem_addr[1:0]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_out) bus.out_stream = OW'($urandom);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'(0));
  endtask

  // Model: every output follows from the cycle offset since the accepted start.
  always @(negedge clk) begin : cmp
    int t, j, d;
    logic e_re, e_cv, e_run, e_done;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_cb;
    logic [NI*DW-1:0] e_in;
    e_re = 0; e_cv = 0; e_run = 0; e_done = 0;
    e_addr = '0; e_cb = '0; e_in = '0; t = 0; j = -1;
    if (m_act) begin
      t = cyc - m_s;
      if (t >= 1 && t <= CW) begin e_re = 1; e_addr = AW'(t - 1); end
      if (t >= 3 && t <= CW + 2) begin e_cv = 1; e_cb = mem[t-3]; end
      j = t - (CW + 3);
      if (j >= 0 && (m_rl == 0 || longint'(j) < longint'(m_rl))) begin
        e_run = 1;
        d = (m_mode == 2'b00) ? 1 : (m_mode == 2'b10) ? 255 : 0;
        for (int i = 0; i < NI; i++) e_in[i*DW +: DW] = DW'(int'(m_seed) + i + j * d);
      end
      if (m_rl != 0 && j >= 0 && longint'(j) == longint'(m_rl)) e_done = 1;
    end
    if (cyc >= 1) begin
      chk("mem_re", 64'(bus.mem_re), 64'(e_re));
      chk("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
      chk("conf_valid", 64'(bus.conf_valid), 64'(e_cv));
      chk("conf_bus", 64'(bus.conf_bus), 64'(e_cb));
      chk("in_stream", 64'(bus.in_stream), 64'(e_in));
      chk("checksum", 64'(checksum), 64'(m_csum));
      chk("busy", 64'(busy), 64'(m_act));
      chk("done", 64'(done), 64'(e_done));
    end
    if (rst) begin
      m_act = 0;
      m_csum = '0;
    end else if (m_act) begin
      if (abort) m_act = 0;
      else begin
        if (e_run) for (int i = 0; i < NO; i++) m_csum = m_csum + CSW'(bus.out_stream[i*DW +: DW]);
        if (e_done) m_act = 0;
      end
    end else if (start && !abort) begin
      m_act = 1; m_s = cyc; m_mode = mode; m_seed = seed; m_rl = run_len; m_csum = '0;
    end
  end

  initial begin
    bus.out_stream = '0;
    mem[0] = 8'hA1; mem[1] = 8'hA2; mem[2] = 8'hA3; mem[3] = 8'hA4;
    tick(); tick();
    rst = 1'b0;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_checksum", 64'(checksum), 64'(0));

    // INC from FE with wrap, config words A1..A4
    mode = 2'b00; seed = 8'hFE; run_len = 32'd3; bus.out_stream = 24'hFFFFFF;
    start = 1'b1; tick(); start = 1'b0;
    chk("lit_addr_t1", 64'(bus.mem_addr), 64'(0));
    ticks(2);
    chk("lit_conf_t3", 64'(bus.conf_bus), 64'h A1);
    ticks(3);
    chk("lit_conf_t6", 64'(bus.conf_bus), 64'h A4);
    tick();
    chk("lit_run0", 64'(bus.in_stream), 64'h 00FFFE);
    tick();
    chk("lit_run1", 64'(bus.in_stream), 64'h 0100FF);
    tick();
    chk("lit_run2", 64'(bus.in_stream), 64'h 020100);
    tick();
    chk("lit_done", 64'(done), 64'(1));
    chk("lit_done_in", 64'(bus.in_stream), 64'(0));
    tick();
    chk("lit_csum3", 64'(checksum), 64'h 8F7);
    ticks(2);

    // HOLD, run_len 4, all lanes FF
    mode = 2'b01; seed = 8'h10; run_len = 32'd4;
    start = 1'b1; tick(); start = 1'b0;
    ticks(8);
    chk("lit_hold", 64'(bus.in_stream), 64'h 121110);
    ticks(3);
    chk("lit_csum4", 64'(checksum), 64'h BF4);
    ticks(3);
    chk("lit_csum_hold", 64'(checksum), 64'h BF4);

    // DEC from 01 with wrap
    rand_out = 1'b1;
    mode = 2'b10; seed = 8'h01; run_len = 32'd3;
    start = 1'b1; tick(); start = 1'b0;
    ticks(6);
    chk("lit_dec0", 64'(bus.in_stream[7:0]), 64'h 01);
    tick();
    chk("lit_dec1", 64'(bus.in_stream[7:0]), 64'h 00);
    tick();
    chk("lit_dec2", 64'(bus.in_stream[7:0]), 64'h FF);
    wait_idle(10);

    // abort mid-LOAD at address 2, then reload from 0
    mode = 2'b00; seed = 8'h30; run_len = 32'd2;
    start = 1'b1; tick(); start = 1'b0;
    ticks(2);
    chk("lit_abort_addr", 64'(bus.mem_addr), 64'(2));
    abort = 1'b1; tick(); abort = 1'b0;
    chk("lit_abort_busy", 64'(busy), 64'(0));
    tick();
    chk("lit_abort_cv", 64'(bus.conf_valid), 64'(0));
    mem[0] = 8'hB1; mem[1] = 8'hB2; mem[2] = 8'hB3; mem[3] = 8'hB4;
    start = 1'b1; tick(); start = 1'b0;
    chk("lit_reload_addr", 64'(bus.mem_addr), 64'(0));
    wait_idle(20);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("lit_start_abort", 64'(busy), 64'(0));

    // rst during an endless RUN, with start pulses while busy
    mode = 2'b00; seed = 8'h55; run_len = 32'd0;
    start = 1'b1; tick(); start = 1'b0;
    ticks(9);
    start = 1'b1; tick(); start = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("lit_rst_busy", 64'(busy), 64'(0));
    chk("lit_rst_in", 64'(bus.in_stream), 64'(0));
    chk("lit_rst_csum", 64'(checksum), 64'(0));
    tick();

    for (int k = 0; k < 25; k++) begin
      for (int a = 0; a < CW; a++) mem[a] = DW'($urandom);
      mode = 2'($urandom); seed = DW'($urandom); run_len = 32'($urandom_range(0, 8));
      start = 1'b1; tick(); start = 1'b0;
      for (int n = 0; n < 80 && busy; n++) begin
        start = ($urandom_range(0, 3) == 0);
        abort = ($urandom_range(0, 29) == 0) || (n == 40);
        tick();
      end
      start = 1'b0; abort = 1'b0;
      wait_idle(4);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
